// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter: FSM states,
// width helpers and the round/shift/saturate output stage.
package fir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } state_e;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } sat_res_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    // Accumulator wide enough that summing NUM_TAPS full-scale products never overflows.
    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned coef_w,
                                          input int unsigned num_taps);
        return data_w + coef_w + clog2(num_taps);
    endfunction

    // Round half up, arithmetic shift right, then clip to a data_w-bit signed range.
    function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                           input int unsigned shift,
                                           input int unsigned data_w);
        logic signed [63:0] bias;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           res;
        bias = (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
        r    = (acc + bias) >>> shift;
        hi   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (data_w - 1));
        res.value = r;
        res.sat   = 1'b0;
        if (r > hi) begin
            res.value = hi;
            res.sat   = 1'b1;
        end else if (r < lo) begin
            res.value = lo;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_filter_tdm_if.sv
// Sample, result and coefficient-write signals of the FIR filter.
// master is the sample source / controller side, slave is the filter.
interface fir_filter_tdm_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned ADDR_W = 2
);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;
    logic                     out_valid;
    logic                     out_ready;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     clear;

    modport master (
        output in_data, in_valid, out_ready, coef_we, coef_addr, coef_wdata, clear,
        input  in_ready, out_data, out_sat, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready, coef_we, coef_addr, coef_wdata, clear,
        output in_ready, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate with synchronous clear.
// sum is the combinational next value so the caller can capture the final tap directly.
module fir_mac
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned ACC_W  = acc_w(16, 16, 4)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [COEF_W-1:0] c,
    output logic signed [ACC_W-1:0]  sum
);
    logic signed [ACC_W-1:0] acc_q;

    always_comb begin
        sum = acc_q + ACC_W'(x) * ACC_W'(c);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end
endmodule

// File: rtl/fir_filter_tdm.sv
// Time-multiplexed NUM_TAPS FIR filter: one tap per cycle through a single MAC,
// run-time writable coefficients, rounded/shifted/saturated output.
module fir_filter_tdm
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned COEF_W   = 16,
    parameter int unsigned NUM_TAPS = 4,
    parameter int unsigned SHIFT    = 0
) (
    input logic           clk,
    input logic           reset,
    fir_filter_tdm_if.slave bus
);
    localparam int unsigned ADDR_W = clog2(NUM_TAPS);
    localparam int unsigned ACC_W  = acc_w(DATA_W, COEF_W, NUM_TAPS);

    state_e                   state_q;
    logic [ADDR_W-1:0]        k_q;
    logic signed [DATA_W-1:0] x_q    [NUM_TAPS];
    logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
    logic signed [DATA_W-1:0] out_data_q;
    logic                     out_sat_q;
    logic                     out_valid_q;

    logic                     idle;
    logic                     last;
    logic signed [ACC_W-1:0]  sum;
    sat_res_t                 res;

    assign idle = (state_q == StIdle);
    assign last = (k_q == ADDR_W'(NUM_TAPS - 1));

    fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (idle && bus.in_valid),
        .en    (state_q == StMac),
        .x     (x_q[k_q]),
        .c     (coef_q[k_q]),
        .sum   (sum)
    );

    always_comb begin
        res = sat_round(64'(sum), SHIFT, DATA_W);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= (i == 0) ? COEF_W'(1) : '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.coef_we && (int'(bus.coef_addr) < NUM_TAPS)) begin
                        coef_q[bus.coef_addr] <= bus.coef_wdata;
                    end
                    // A clear arriving with a sample wipes the history before the shift.
                    if (bus.in_valid) begin
                        x_q[0] <= bus.in_data;
                        for (int i = 1; i < NUM_TAPS; i++) begin
                            x_q[i] <= bus.clear ? '0 : x_q[i-1];
                        end
                        k_q     <= '0;
                        state_q <= StMac;
                    end else if (bus.clear) begin
                        for (int i = 0; i < NUM_TAPS; i++) begin
                            x_q[i] <= '0;
                        end
                    end
                end
                StMac: begin
                    k_q <= k_q + ADDR_W'(1);
                    if (last) begin
                        out_data_q  <= DATA_W'(res.value);
                        out_sat_q   <= res.sat;
                        out_valid_q <= 1'b1;
                        k_q         <= '0;
                        state_q     <= StOut;
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = idle;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_fir_filter_tdm.sv
// Scoreboard bench: two filters (SHIFT=0 and SHIFT=2) driven in lockstep, each checked
// against a direct convolution model of the filter equation.
module tb_fir_filter_tdm;
    localparam int NT = 4;

    typedef struct {
        int data;
        bit sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fir_filter_tdm_if #(.DATA_W(16), .COEF_W(16), .ADDR_W(2)) b0 ();
    fir_filter_tdm_if #(.DATA_W(16), .COEF_W(16), .ADDR_W(2)) b1 ();

    fir_filter_tdm #(.DATA_W(16), .COEF_W(16), .NUM_TAPS(NT), .SHIFT(0)) dut0 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b0)
    );
    fir_filter_tdm #(.DATA_W(16), .COEF_W(16), .NUM_TAPS(NT), .SHIFT(2)) dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b1)
    );

    int   compared   = 0;
    int   mismatched = 0;
    int   coef_m [NT];
    int   hist   [NT];
    exp_t q0 [$];
    exp_t q1 [$];
    bit   rand_ready = 1'b0;

    function automatic exp_t model(input int shift);
        longint acc, d, num, r;
        exp_t   e;
        acc = 0;
        for (int i = 0; i < NT; i++) acc += longint'(coef_m[i]) * longint'(hist[i]);
        d   = longint'(1) << shift;
        num = acc + ((shift > 0) ? d / 2 : 0);
        r   = (num >= 0) ? num / d : -((-num + d - 1) / d);
        e.sat = 1'b0;
        if (r > 32767) begin
            r = 32767;
            e.sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            e.sat = 1'b1;
        end
        e.data = int'(r);
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NT; i++) begin
            coef_m[i] = (i == 0) ? 1 : 0;
            hist[i]   = 0;
        end
    endfunction

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (b0.in_ready === 1'b1 && b1.in_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        compared++;
        mismatched++;
        $display("FAIL wait_idle: in_ready got 0 want 1 within 200 cycles");
    endtask

    // Sample accept, optionally with a same-cycle coefficient write.
    task automatic send_w(input int s, input bit clr, input bit we, input int addr, input int val);
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        b0.in_data = 16'(s);   b1.in_data = 16'(s);
        b0.in_valid = 1'b1;    b1.in_valid = 1'b1;
        b0.clear = clr;        b1.clear = clr;
        b0.coef_we = we;       b1.coef_we = we;
        b0.coef_addr = 2'(addr); b1.coef_addr = 2'(addr);
        b0.coef_wdata = 16'(val); b1.coef_wdata = 16'(val);
        @(posedge clk);
        #1;
        b0.in_valid = 1'b0; b1.in_valid = 1'b0;
        b0.clear = 1'b0;    b1.clear = 1'b0;
        b0.coef_we = 1'b0;  b1.coef_we = 1'b0;
        if (we && addr < NT) coef_m[addr] = val;
        if (clr) for (int i = 0; i < NT; i++) hist[i] = 0;
        for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s;
        q0.push_back(model(0));
        q1.push_back(model(2));
    endtask

    task automatic send(input int s, input bit clr);
        send_w(s, clr, 1'b0, 0, 0);
    endtask

    task automatic write_coef(input int addr, input int val);
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        b0.coef_we = 1'b1;        b1.coef_we = 1'b1;
        b0.coef_addr = 2'(addr);  b1.coef_addr = 2'(addr);
        b0.coef_wdata = 16'(val); b1.coef_wdata = 16'(val);
        @(posedge clk);
        #1;
        b0.coef_we = 1'b0; b1.coef_we = 1'b0;
        if (addr < NT) coef_m[addr] = val;
    endtask

    task automatic do_clear();
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        b0.clear = 1'b1; b1.clear = 1'b1;
        @(posedge clk);
        #1;
        b0.clear = 1'b0; b1.clear = 1'b0;
        for (int i = 0; i < NT; i++) hist[i] = 0;
    endtask

    task automatic drain();
        for (int c = 0; c < 400; c++) begin
            if (q0.size() == 0 && q1.size() == 0) return;
            @(posedge clk);
            #1;
        end
        compared++;
        mismatched++;
        $display("FAIL drain: outstanding got %0d/%0d want 0/0", q0.size(), q1.size());
        q0.delete();
        q1.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid0"}, int'(b0.out_valid), 0);
        check({tag, "_in_ready0"},  int'(b0.in_ready), 1);
        check({tag, "_out_valid1"}, int'(b1.out_valid), 0);
        check({tag, "_in_ready1"},  int'(b1.in_ready), 1);
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && b0.out_valid === 1'b1 && b0.out_ready === 1'b1) begin
            compared++;
            if (q0.size() == 0) begin
                mismatched++;
                $display("FAIL out0_unexpected: got %0d with empty queue", $signed(b0.out_data));
            end else begin
                e = q0.pop_front();
                if ($signed(b0.out_data) !== e.data || b0.out_sat !== e.sat) begin
                    mismatched++;
                    $display("FAIL out0: got %0d sat %0d want %0d sat %0d",
                             $signed(b0.out_data), b0.out_sat, e.data, e.sat);
                end
            end
        end
        if (rst_n === 1'b1 && b1.out_valid === 1'b1 && b1.out_ready === 1'b1) begin
            compared++;
            if (q1.size() == 0) begin
                mismatched++;
                $display("FAIL out1_unexpected: got %0d with empty queue", $signed(b1.out_data));
            end else begin
                e = q1.pop_front();
                if ($signed(b1.out_data) !== e.data || b1.out_sat !== e.sat) begin
                    mismatched++;
                    $display("FAIL out1: got %0d sat %0d want %0d sat %0d",
                             $signed(b1.out_data), b1.out_sat, e.data, e.sat);
                end
            end
        end
    end

    always @(posedge clk) begin
        bit r;
        #1;
        if (rand_ready) begin
            r = 1'($urandom_range(0, 1));
            b0.out_ready = r;
            b1.out_ready = r;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] d0, d1;
        logic               s0, s1;
        int                 n;
        bit                 seen;

        rst_n = 1'b0;
        b0.in_data = '0;  b0.in_valid = 1'b0; b0.out_ready = 1'b1; b0.coef_we = 1'b0;
        b0.coef_addr = '0; b0.coef_wdata = '0; b0.clear = 1'b0;
        b1.in_data = '0;  b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.coef_we = 1'b0;
        b1.coef_addr = '0; b1.coef_wdata = '0; b1.clear = 1'b0;
        model_reset();

        #1;
        check_reset_outputs("in_reset");
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_data0", int'($signed(b0.out_data)), 0);
        check("rst_out_sat0", int'(b0.out_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("after_reset");

        // Passthrough defaults
        send(5, 1'b0); send(-7, 1'b0); send(100, 1'b0);
        drain();

        // Coefficients {1,2,3,2}: impulse then step
        write_coef(0, 1); write_coef(1, 2); write_coef(2, 3); write_coef(3, 2);
        send(1, 1'b0);
        repeat (4) send(0, 1'b0);
        repeat (5) send(10, 1'b0);
        drain();

        // Saturation at both rails
        for (int i = 0; i < NT; i++) write_coef(i, 16384);
        repeat (4) send(32767, 1'b0);
        repeat (4) send(-32768, 1'b0);
        drain();

        // Rounding half up, clear together with a sample, clear on its own
        write_coef(0, 1); write_coef(1, 0); write_coef(2, 0); write_coef(3, 0);
        send(6, 1'b1);
        send(-6, 1'b1);
        write_coef(1, 1);
        send(40, 1'b0);
        do_clear();
        send(3, 1'b0);
        drain();

        // Coefficient write in the same cycle as a sample accept
        send_w(4, 1'b0, 1'b1, 1, 5);
        drain();

        // Backpressure: output held, input blocked
        b0.out_ready = 1'b0; b1.out_ready = 1'b0;
        send(1234, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (b0.out_valid === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("bp_out_valid", int'(seen), 1);
        d0 = b0.out_data; d1 = b1.out_data; s0 = b0.out_sat; s1 = b1.out_sat;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_hold0", int'($signed(b0.out_data)), int'(d0));
            check("bp_hold1", int'($signed(b1.out_data)), int'(d1));
            check("bp_sat_hold", int'({b0.out_sat, b1.out_sat}), int'({s0, s1}));
            check("bp_in_ready", int'({b0.in_ready, b1.in_ready}), 0);
        end
        b0.out_ready = 1'b1; b1.out_ready = 1'b1;
        drain();

        // Write issued during MAC must be dropped
        send(0, 1'b1);
        b0.coef_we = 1'b1; b1.coef_we = 1'b1;
        b0.coef_addr = 2'd0; b1.coef_addr = 2'd0;
        b0.coef_wdata = 16'sd77; b1.coef_wdata = 16'sd77;
        @(posedge clk);
        #1;
        b0.coef_we = 1'b0; b1.coef_we = 1'b0;
        drain();
        send(1, 1'b1);
        send(0, 1'b0);
        drain();

        // Reset at MAC cycle 2 discards the sample and restores defaults
        write_coef(0, 2); write_coef(1, 3); write_coef(2, 4); write_coef(3, 5);
        send(7, 1'b0);
        send(9, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        q0.delete();
        q1.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 1'b0);
        send(0, 1'b0);
        send(-300, 1'b0);
        drain();

        // Randomised traffic with random downstream stalls
        rand_ready = 1'b1;
        for (int it = 0; it < 80; it++) begin
            n = $urandom_range(0, 9);
            if (n < 2) write_coef($urandom_range(0, NT - 1), $urandom_range(0, 1200) - 600);
            else if (n == 2) do_clear();
            else send($urandom_range(0, 65535) - 32768, ($urandom_range(0, 9) == 0));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        b0.out_ready = 1'b1; b1.out_ready = 1'b1;
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fir_filter_tdm.md
Name: fir_filter_tdm

Overview:
Parametrised, time-multiplexed FIR filter that generalises the fixed 4-tap filter to NUM_TAPS taps. It uses a single multiply-accumulate stage, so it performs one tap per cycle. Coefficients are run-time writable, input and output use valid/ready handshakes, and the output is rounded, scaled and saturated. It sits between the accelerometer sample source and downstream processing.

Parameters:
DATA_W, 16, signed sample width (in and out)
COEF_W, 16, signed coefficient width
NUM_TAPS, 4, number of taps; minimum 2
SHIFT, 0, arithmetic right shift applied to the accumulator before output, 0..COEF_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_data  in  DATA_W  signed input sample
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample; equals (state==IDLE)
out_data  out  DATA_W  filtered sample
out_sat  out  1  out_data was clipped for this sample
out_valid  out  1  output valid
out_ready  in  1  downstream accepts
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(NUM_TAPS)  tap index
coef_wdata  in  COEF_W  signed coefficient
clear  in  1  zero the delay line; honoured only in IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, out_valid=0, out_data=0, out_sat=0.
  - All delay-line taps x[i]=0.
  - coef[0]=1, all other coefficients 0 (passthrough).
- Accumulator width: ACC_W = DATA_W+COEF_W+clog2(NUM_TAPS). No internal overflow is possible.
- Function: y[n] = sum over i=0..NUM_TAPS-1 of coef[i]*x[n-i], where x[n] is the newest accepted sample.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: shift the delay line (x[0]<=in_data, x[i]<=x[i-1]), acc<=0, k<=0, go to MAC.
  - clear=1 with no in_valid: all x[i]<=0.
  - clear and in_valid in the same cycle: clear is applied first, then the shift. Result: x[0]=in_data, all other taps 0.
- MAC:
  - Each cycle: acc<=acc+coef[k]*x[k], k<=k+1.
  - On k==NUM_TAPS-1: register the final result into out_data/out_sat and go to OUT.
- OUT:
  - out_valid=1; out_data and out_sat are held stable until out_ready=1.
  - On out_ready: go to IDLE.
- Latency and throughput:
  - Accept edge at cycle 0; out_valid first high in cycle NUM_TAPS.
  - Minimum sample period is NUM_TAPS+2 cycles with out_ready tied high.
- Output scaling:
  - r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, i.e. round half up.
  - r is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_sat=1 if and only if saturation occurred.
- Coefficient writes:
  - Accepted only in IDLE; coef_we in MAC or OUT is ignored (dropped, not queued).
  - A write in the same cycle as a sample accept takes effect for that sample.
  - coef_addr >= NUM_TAPS is ignored.
- Reset mid-operation: the in-flight sample is discarded and the block returns to the reset state immediately.

Decomposition:
- Package fir_pkg:
  - state enum {IDLE, MAC, OUT}
  - clog2 function
  - ACC_W computation function
  - sat_round function (round, shift, saturate; returns value and flag)
- Sub-module fir_mac: registered signed multiply-accumulate with a synchronous acc clear. The top level holds the FSM, delay line and coefficient registers.

Test Plan:
- Reset defaults, then input stream 5, -7, 100: out_data 5, -7, 100 (passthrough). Check out_valid=0 and in_ready=1 during and after reset.
- Write coefficients {1,2,3,2} with SHIFT=0, then impulse 1 followed by four 0 samples: outputs 1, 2, 3, 2, 0. Then a step of 10 for five samples: 10, 30, 60, 80, 80.
- Saturation with DATA_W=16 and all coefficients 16384:
  - Four samples of 32767: out_data=32767, out_sat=1 once the sum exceeds range.
  - Four samples of -32768: -32768, out_sat=1.
- Rounding with SHIFT=2 and coefficients {1,0,0,0}:
  - Input 6 gives 2 (6/4 = 1.5 rounds up).
  - Input -6 gives -1 (-6/4 = -1.5 rounds half up).
- Backpressure and ignored writes:
  - Hold out_ready=0 for 5 cycles in OUT: out_data stable, in_ready=0.
  - coef_we during MAC: the coefficient is unchanged on read-back by the next impulse.
- Reset asserted at MAC cycle 2: out_valid=0 and in_ready=1 immediately; coefficients and delay line return to reset values; the next impulse gives passthrough.
